// File: rtl/exec_cc_unit_pkg.sv
// Shared constants for the execute-stage condition-code unit:
// instruction codes, condition function codes, register and status encodings.
package exec_cc_unit_pkg;

  localparam logic [3:0] icode_nop  = 4'h1;
  localparam logic [3:0] icode_cmov = 4'h2;
  localparam logic [3:0] icode_jxx  = 4'h7;

  localparam logic [3:0] c_yes = 4'd0;
  localparam logic [3:0] c_le  = 4'd1;
  localparam logic [3:0] c_l   = 4'd2;
  localparam logic [3:0] c_e   = 4'd3;
  localparam logic [3:0] c_ne  = 4'd4;
  localparam logic [3:0] c_ge  = 4'd5;
  localparam logic [3:0] c_g   = 4'd6;

  localparam logic [3:0] rnone    = 4'hF;
  localparam logic [2:0] stat_aok = 3'd1;

  // CC bit order is {ZF,SF,OF}; reset leaves "result was zero".
  localparam logic [2:0] cc_reset = 3'b100;

endpackage

// File: rtl/exec_cc_unit_cond_eval.sv
// Purely combinational branch/cmov condition evaluation from a {ZF,SF,OF} flag set.
module cond_eval
  import exec_cc_unit_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic zf, sf, of;

  assign zf = cc[2];
  assign sf = cc[1];
  assign of = cc[0];

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      c_yes:   cnd = 1'b1;
      c_le:    cnd = (sf ^ of) | zf;
      c_l:     cnd = sf ^ of;
      c_e:     cnd = zf;
      c_ne:    cnd = ~zf;
      c_ge:    cnd = ~(sf ^ of);
      c_g:     cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_cc_unit.sv
// Execute stage: condition-code register, condition evaluation, cmov squash
// and the E/M pipeline register (stall > bubble > load).
module exec_cc_unit
  import exec_cc_unit_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   alu_cc,
  input  logic         set_cc,
  input  logic         exc_block,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] E_valE,
  input  logic [W-1:0] E_valA,
  input  logic [3:0]   E_dstE,
  input  logic [3:0]   E_dstM,
  input  logic [2:0]   E_stat,
  input  logic         M_stall,
  input  logic         M_bubble,
  output logic [2:0]   cc_q,
  output logic         e_cnd,
  output logic [3:0]   e_dstE,
  output logic [3:0]   M_icode,
  output logic         M_cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM,
  output logic [2:0]   M_stat
);

  // Condition uses the flags as they stand before this cycle's update.
  cond_eval u_cond_eval (
    .cc   (cc_q),
    .ifun (E_ifun),
    .cnd  (e_cnd)
  );

  assign e_dstE = ((E_icode == icode_cmov) && !e_cnd) ? rnone : E_dstE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= cc_reset;
    end else if (set_cc && !exc_block) begin
      cc_q <= alu_cc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_icode <= icode_nop;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= rnone;
      M_dstM  <= rnone;
      M_stat  <= stat_aok;
    end else if (!M_stall) begin
      if (M_bubble) begin
        M_icode <= icode_nop;
        M_cnd   <= 1'b0;
        M_valE  <= '0;
        M_valA  <= '0;
        M_dstE  <= rnone;
        M_dstM  <= rnone;
        M_stat  <= stat_aok;
      end else begin
        M_icode <= E_icode;
        M_cnd   <= e_cnd;
        M_valE  <= E_valE;
        M_valA  <= E_valA;
        M_dstE  <= e_dstE;
        M_dstM  <= E_dstM;
        M_stat  <= E_stat;
      end
    end
  end

endmodule

// File: tb/tb_exec_cc_unit.sv
// Self-checking bench for exec_cc_unit: reference model plus a queue of
// expected E/M register contents compared one cycle after each drive.
module tb_exec_cc_unit;

  localparam int W = 64;

  logic         clk, rst_n;
  logic [2:0]   alu_cc;
  logic         set_cc, exc_block;
  logic [3:0]   E_icode, E_ifun, E_dstE, E_dstM;
  logic [W-1:0] E_valE, E_valA;
  logic [2:0]   E_stat;
  logic         M_stall, M_bubble;
  logic [2:0]   cc_q;
  logic         e_cnd;
  logic [3:0]   e_dstE;
  logic [3:0]   M_icode;
  logic         M_cnd;
  logic [W-1:0] M_valE, M_valA;
  logic [3:0]   M_dstE, M_dstM;
  logic [2:0]   M_stat;

  exec_cc_unit #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .alu_cc(alu_cc), .set_cc(set_cc), .exc_block(exc_block),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_valE(E_valE), .E_valA(E_valA),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_stat(E_stat),
    .M_stall(M_stall), .M_bubble(M_bubble),
    .cc_q(cc_q), .e_cnd(e_cnd), .e_dstE(e_dstE),
    .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_stat(M_stat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   icode;
    logic         cnd;
    logic [W-1:0] vale;
    logic [W-1:0] vala;
    logic [3:0]   dste;
    logic [3:0]   dstm;
    logic [2:0]   stat;
  } em_t;

  em_t  sbq[$];
  em_t  m_cur;
  logic [2:0] m_cc;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic em_t bubble_val();
    em_t b;
    b = '{4'h1, 1'b0, '0, '0, 4'hF, 4'hF, 3'd1};
    return b;
  endfunction

  function automatic logic cond_model(input logic [2:0] cc, input logic [3:0] fn);
    logic zf, sf, of, lt;
    zf = cc[2]; sf = cc[1]; of = cc[0];
    lt = sf ^ of;
    if (fn == 4'd0) return 1'b1;
    if (fn == 4'd1) return lt | zf;
    if (fn == 4'd2) return lt;
    if (fn == 4'd3) return zf;
    if (fn == 4'd4) return !zf;
    if (fn == 4'd5) return !lt;
    if (fn == 4'd6) return !lt && !zf;
    return 1'b0;
  endfunction

  task automatic check_em(input string tag, input em_t e);
    chk({tag, ".icode"}, 64'(M_icode), 64'(e.icode));
    chk({tag, ".cnd"},   64'(M_cnd),   64'(e.cnd));
    chk({tag, ".vale"},  M_valE,       e.vale);
    chk({tag, ".vala"},  M_valA,       e.vala);
    chk({tag, ".dste"},  64'(M_dstE),  64'(e.dste));
    chk({tag, ".dstm"},  64'(M_dstM),  64'(e.dstm));
    chk({tag, ".stat"},  64'(M_stat),  64'(e.stat));
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    logic c;
    logic [3:0] d;
    em_t nx, got;
    #1;
    c = cond_model(m_cc, E_ifun);
    d = (E_icode == 4'h2 && !c) ? 4'hF : E_dstE;
    chk("cc_q",   64'(cc_q),   64'(m_cc));
    chk("e_cnd",  64'(e_cnd),  64'(c));
    chk("e_dstE", 64'(e_dstE), 64'(d));
    if (M_stall)       nx = m_cur;
    else if (M_bubble) nx = bubble_val();
    else               nx = '{E_icode, c, E_valE, E_valA, d, E_dstM, E_stat};
    sbq.push_back(nx);
    m_cur = nx;
    if (set_cc && !exc_block) m_cc = alu_cc;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_total++;
      $display("FAIL sb_empty: no expected entry queued");
    end else begin
      got = sbq.pop_front();
      check_em("em", got);
    end
    chk("cc_next", 64'(cc_q), 64'(m_cc));
    @(negedge clk);
  endtask

  task automatic rand_ops();
    E_valE = {$urandom, $urandom};
    E_valA = {$urandom, $urandom};
    E_dstE = 4'($urandom_range(0, 15));
    E_dstM = 4'($urandom_range(0, 15));
    E_stat = 3'($urandom_range(1, 4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; alu_cc = '0; set_cc = 1'b0; exc_block = 1'b0;
    E_icode = 4'h6; E_ifun = 4'h0; E_valE = '0; E_valA = '0;
    E_dstE = 4'h3; E_dstM = 4'hF; E_stat = 3'd1; M_stall = 1'b0; M_bubble = 1'b0;
    m_cc = 3'b100; m_cur = bubble_val();

    // Asynchronous reset mid-cycle, checked without any clock edge.
    #7 rst_n = 1'b0;
    #1;
    chk("rst_cc_q",    64'(cc_q),    64'h4);
    chk("rst_M_icode", 64'(M_icode), 64'h1);
    chk("rst_M_dstE",  64'(M_dstE),  64'hF);
    check_em("rst", bubble_val());
    @(negedge clk);
    rst_n = 1'b1;

    // CC load then condition from the new flags.
    alu_cc = 3'b011; set_cc = 1'b1; E_icode = 4'h6; E_ifun = 4'h0; rand_ops();
    cycle();
    set_cc = 1'b0; E_ifun = 4'h2; rand_ops();
    cycle();
    E_ifun = 4'h5; rand_ops();
    cycle();

    // Suppressed update.
    set_cc = 1'b1; exc_block = 1'b1; alu_cc = 3'b010; rand_ops();
    cycle();
    set_cc = 1'b0; exc_block = 1'b0;
    cycle();

    // cmov squash with all flags clear.
    alu_cc = 3'b000; set_cc = 1'b1; rand_ops();
    cycle();
    set_cc = 1'b0; E_icode = 4'h2; E_ifun = 4'h3; E_dstE = 4'h3;
    cycle();

    // Stall wins over bubble, bubble alone, and stall does not block CC.
    E_icode = 4'h6; E_ifun = 4'h0; rand_ops();
    M_stall = 1'b1; M_bubble = 1'b1;
    cycle();
    M_stall = 1'b0;
    cycle();
    M_bubble = 1'b0; rand_ops();
    cycle();
    M_stall = 1'b1; set_cc = 1'b1; alu_cc = 3'b110; rand_ops();
    cycle();
    M_stall = 1'b0; set_cc = 1'b0;
    cycle();

    // Full condition table sweep with a sprinkle of stalls and bubbles.
    for (int cc = 0; cc < 8; cc++) begin
      alu_cc = 3'(cc); set_cc = 1'b1; M_stall = 1'b0; M_bubble = 1'b0;
      E_icode = 4'h6; E_ifun = 4'h0; rand_ops();
      cycle();
      set_cc = 1'b0;
      for (int fn = 0; fn < 16; fn++) begin
        E_ifun   = 4'(fn);
        E_icode  = (fn % 2 == 1) ? 4'h2 : 4'h6;
        M_stall  = ($urandom_range(0, 7) == 0);
        M_bubble = ($urandom_range(0, 7) == 0);
        rand_ops();
        cycle();
      end
    end

    // Reset in the middle of a pending update discards it.
    M_stall = 1'b0; M_bubble = 1'b0;
    alu_cc = 3'b001; set_cc = 1'b1; E_icode = 4'h6; E_ifun = 4'h0; rand_ops();
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_cc_q",    64'(cc_q),    64'h4);
    chk("rst2_M_icode", 64'(M_icode), 64'h1);
    chk("rst2_M_valE",  M_valE,       64'h0);
    m_cc = 3'b100; m_cur = bubble_val(); sbq.delete();
    @(negedge clk);
    chk("rst2_hold_cc", 64'(cc_q), 64'h4);
    rst_n = 1'b1;
    cycle();
    set_cc = 1'b0; E_ifun = 4'h2; rand_ops();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exec_cc_unit.md
EXEC_CC_UNIT -- requirements
Module: exec_cc_unit

Interface
REQ-001 SHALL have parameter W, default 64, datapath width of valE/valA.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port alu_cc  input  3  ALU flags {ZF,SF,OF} (bit2=ZF, bit1=SF, bit0=OF).
REQ-005 SHALL have port set_cc  input  1  load alu_cc into CC register this cycle.
REQ-006 SHALL have port exc_block  input  1  downstream exception present; suppresses CC update.
REQ-007 SHALL have ports E_icode, E_ifun  input  4 each  instruction in execute.
REQ-008 SHALL have ports E_valE, E_valA  input  W each  ALU result, forwarded operand A.
REQ-009 SHALL have ports E_dstE, E_dstM  input  4 each  destination register IDs (0xF = none).
REQ-010 SHALL have port E_stat  input  3  instruction status.
REQ-011 SHALL have ports M_stall, M_bubble  input  1 each  E/M register hold / inject NOP.
REQ-012 SHALL have port cc_q  output  3  current CC register.
REQ-013 SHALL have port e_cnd  output  1  combinational condition result.
REQ-014 SHALL have port e_dstE  output  4  combinational effective dstE (after cmov squash).
REQ-015 SHALL have ports M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM, M_stat  output  4/1/W/W/4/4/3  registered E/M stage.

Function
REQ-016 CC register SHALL load alu_cc on rising clk iff set_cc=1 and exc_block=0; otherwise hold.
REQ-017 e_cnd SHALL be evaluated from cc_q (pre-update value), never from alu_cc.
REQ-018 e_cnd by E_ifun: 0 ->1; 1 ->(SF^OF)|ZF; 2 ->SF^OF; 3 ->ZF; 4 ->~ZF; 5 ->~(SF^OF); 6 ->~(SF^OF)&~ZF; 7-15 ->0.
REQ-019 e_dstE SHALL equal 4'hF when E_icode=4'h2 (cmov) and e_cnd=0; else E_dstE.
REQ-020 E/M register, priority M_stall > M_bubble > load: stall holds all M_* outputs.
REQ-021 Bubble SHALL load M_icode=4'h1, M_stat=3'd1, M_dstE=M_dstM=4'hF, M_cnd=0, M_valE=M_valA=0.
REQ-022 Normal load SHALL capture E_icode, e_cnd, E_valE, E_valA, e_dstE, E_dstM, E_stat; latency one cycle.
REQ-023 CC update and E/M load SHALL be independent: M_stall SHALL NOT block a CC update.
REQ-024 set_cc=1 with exc_block=1 in same cycle SHALL leave cc_q unchanged.
REQ-025 M_valE/M_valA SHALL be full W bits, no truncation or sign change.

Reset
REQ-026 rst_n low SHALL asynchronously force cc_q=3'b100 (ZF=1,SF=0,OF=0).
REQ-027 rst_n low SHALL asynchronously force E/M register to bubble values of REQ-021.
REQ-028 Reset asserted mid-operation SHALL discard pending updates; first load occurs on first rising clk after rst_n high.

Structure
REQ-029 Shared package SHALL hold icode constants (NOP=1, CMOV=2, JXX=7), ifun condition codes 0-6, RNONE=4'hF, stat codes (AOK=1).
REQ-030 Condition evaluation SHALL be sub-module cond_eval (inputs cc, ifun; output cnd).
REQ-031 All state SHALL be in exec_cc_unit; cond_eval SHALL be purely combinational.

Verification
REQ-032 Reset: assert rst_n=0 mid-cycle -> cc_q=3'b100, M_icode=1, M_dstE=F immediately, without clk edge.
REQ-033 CC load: alu_cc=3'b011, set_cc=1 -> next cycle cc_q=3'b011; E_ifun=2 gives e_cnd=0, E_ifun=5 gives e_cnd=1.
REQ-034 Suppression: set_cc=1, exc_block=1, alu_cc=3'b010 -> cc_q remains prior value.
REQ-035 Cmov squash: cc_q=3'b000, E_icode=2, E_ifun=3, E_dstE=3 -> e_dstE=F, next cycle M_dstE=F, M_cnd=0.
REQ-036 Stall vs bubble: M_stall=1 and M_bubble=1 -> M_* unchanged; M_bubble alone -> NOP values next cycle.
REQ-037 Full table: sweep all 8 cc_q values x ifun 0-15 -> e_cnd matches REQ-018 exactly.
